// File: rtl/ucom43_sys_ctrl_if.sv
// ----------------------------------------------------------------------------
// ucom43_sys_ctrl_if
//   Bundle of the download, control and core-facing signals of the
//   uCOM-43 boot/run sequencer.
//
//   master : top-level glue side (drives download/pause/button, observes
//            ROM-init and CPU control outputs)
//   slave  : ucom43_sys_ctrl side
//
//   Signals
//     dl_active, dl_wr, dl_addr[15:0], dl_data[7:0]  HPS download channel
//     pause, int_btn                                 run control / button
//     rom_init, rom_init_addr[11:0], rom_init_data   ROM-init write port
//     cpu_reset, cpu_ce, int_n                       core control
//     rom_valid, busy                                status
//     rom_sum[15:0]                                  only with UCOM43_ROM_SUM_EN
// ----------------------------------------------------------------------------
interface ucom43_sys_ctrl_if;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        pause;
    logic        int_btn;
    logic        rom_init;
    logic [11:0] rom_init_addr;
    logic [7:0]  rom_init_data;
    logic        cpu_reset;
    logic        cpu_ce;
    logic        int_n;
    logic        rom_valid;
    logic        busy;
`ifdef UCOM43_ROM_SUM_EN
    logic [15:0] rom_sum;

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, pause, int_btn,
        input  rom_init, rom_init_addr, rom_init_data, cpu_reset, cpu_ce,
               int_n, rom_valid, busy, rom_sum
    );
    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, pause, int_btn,
        output rom_init, rom_init_addr, rom_init_data, cpu_reset, cpu_ce,
               int_n, rom_valid, busy, rom_sum
    );
`else
    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, pause, int_btn,
        input  rom_init, rom_init_addr, rom_init_data, cpu_reset, cpu_ce,
               int_n, rom_valid, busy
    );
    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, pause, int_btn,
        output rom_init, rom_init_addr, rom_init_data, cpu_reset, cpu_ce,
               int_n, rom_valid, busy
    );
`endif
endinterface

// File: rtl/ucom43_sys_ctrl.sv
// ----------------------------------------------------------------------------
// ucom43_sys_ctrl
//   Boot/run sequencer for the uCOM-43 core. Streams the downloaded ROM image
//   into the core's ROM-init port, holds the CPU in reset until a complete
//   image is present, generates the CPU clock-enable (with pause) and turns
//   the asynchronous cabinet button into a timed active-low _INT pulse.
//
//   Ports
//     clk    : system clock
//     reset  : asynchronous, active-high reset
//     bus    : ucom43_sys_ctrl_if.slave (download, pause, button, ROM-init,
//              cpu_reset, cpu_ce, int_n, rom_valid, busy)
//
//   Build option
//     UCOM43_ROM_SUM_EN : adds bus.rom_sum (mod-2^16 byte sum of the current
//                         load) and parameter EXP_SUM; an image is accepted
//                         only when both byte count and sum match.
// ----------------------------------------------------------------------------
module ucom43_sys_ctrl #(
    parameter int unsigned ROM_SIZE  = 2048,
    parameter int unsigned CE_DIV    = 4,
    parameter int unsigned RST_HOLD  = 16,
    parameter int unsigned INT_PULSE = 8
`ifdef UCOM43_ROM_SUM_EN
    ,
    parameter logic [15:0] EXP_SUM   = 16'h0000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    ucom43_sys_ctrl_if.slave bus
);

    localparam int unsigned       CNT_W     = $clog2(ROM_SIZE + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(ROM_SIZE);
    localparam logic [16:0]       ADDR_LIM  = 17'(ROM_SIZE);
    localparam logic [7:0]        DIV_LAST  = 8'(CE_DIV - 1);
    localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam int unsigned       INT_W     = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
    localparam logic [INT_W-1:0]  INT_LAST  = INT_W'(INT_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_PAUSED
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [7:0]        r_div;
    logic [INT_W-1:0]  r_int_cnt;
    logic              r_btn_s1;
    logic              r_btn_s2;
    logic              r_btn_d;
    logic              r_rom_init;
    logic [11:0]       r_rom_addr;
    logic [7:0]        r_rom_data;
    logic              r_cpu_reset;
    logic              r_cpu_ce;
    logic              r_int_n;
    logic              r_rom_valid;
    logic              r_busy;
`ifdef UCOM43_ROM_SUM_EN
    logic [15:0]       r_sum;
    logic [15:0]       w_sum_nxt;
`endif

    logic              w_wr_ok;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_img_ok;
    logic              w_btn_rise;

    // Count and sum include a write arriving in the same cycle that
    // dl_active drops, so the completeness check sees the final byte.
    always_comb begin
        w_wr_ok    = bus.dl_wr && ({1'b0, bus.dl_addr} < ADDR_LIM);
        w_cnt_nxt  = r_cnt;
        if (w_wr_ok && (r_cnt != CNT_FULL)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        w_btn_rise = r_btn_s2 & ~r_btn_d;
`ifdef UCOM43_ROM_SUM_EN
        w_sum_nxt  = w_wr_ok ? (r_sum + {8'h00, bus.dl_data}) : r_sum;
        w_img_ok   = (w_cnt_nxt == CNT_FULL) && (w_sum_nxt == EXP_SUM);
`else
        w_img_ok   = (w_cnt_nxt == CNT_FULL);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hold_cnt  <= '0;
            r_div       <= '0;
            r_int_cnt   <= '0;
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_d     <= 1'b0;
            r_rom_init  <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_data  <= '0;
            r_cpu_reset <= 1'b1;
            r_cpu_ce    <= 1'b0;
            r_int_n     <= 1'b1;
            r_rom_valid <= 1'b0;
            r_busy      <= 1'b1;
`ifdef UCOM43_ROM_SUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_btn_s1   <= bus.int_btn;
            r_btn_s2   <= r_btn_s1;
            r_btn_d    <= r_btn_s2;
            r_rom_init <= 1'b0;
            r_cpu_ce   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.dl_active) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
`ifdef UCOM43_ROM_SUM_EN
                        r_sum   <= '0;
`endif
                    end
                end

                S_LOAD: begin
                    if (w_wr_ok) begin
                        r_rom_init <= 1'b1;
                        r_rom_addr <= bus.dl_addr[11:0];
                        r_rom_data <= bus.dl_data;
                    end
                    r_cnt <= w_cnt_nxt;
`ifdef UCOM43_ROM_SUM_EN
                    r_sum <= w_sum_nxt;
`endif
                    if (!bus.dl_active) begin
                        if (w_img_ok) begin
                            r_rom_valid <= 1'b1;
                            r_hold_cnt  <= '0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_rom_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end

                S_HOLD: begin
                    if (bus.dl_active) begin
                        r_state     <= S_LOAD;
                        r_cnt       <= '0;
                        r_rom_valid <= 1'b0;
`ifdef UCOM43_ROM_SUM_EN
                        r_sum       <= '0;
`endif
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_div       <= '0;
                        r_int_cnt   <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                S_RUN, S_PAUSED: begin
                    if (bus.dl_active) begin
                        r_state     <= S_LOAD;
                        r_cnt       <= '0;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b1;
                        r_int_n     <= 1'b1;
                        r_int_cnt   <= '0;
                        r_rom_valid <= 1'b0;
`ifdef UCOM43_ROM_SUM_EN
                        r_sum       <= '0;
`endif
                    end else begin
                        // Ticks are counted from the registered cpu_ce, which
                        // is never high while PAUSED, so the pulse counter
                        // freezes naturally during a pause.
                        if (r_int_n) begin
                            if (w_btn_rise) begin
                                r_int_n   <= 1'b0;
                                r_int_cnt <= '0;
                            end
                        end else if (r_cpu_ce) begin
                            if (r_int_cnt == INT_LAST) begin
                                r_int_n <= 1'b1;
                            end else begin
                                r_int_cnt <= r_int_cnt + 1'b1;
                            end
                        end

                        if (r_state == S_RUN) begin
                            if (bus.pause) begin
                                r_state <= S_PAUSED;
                            end else if (r_div == DIV_LAST) begin
                                r_div    <= '0;
                                r_cpu_ce <= 1'b1;
                            end else begin
                                r_div <= r_div + 1'b1;
                            end
                        end else if (!bus.pause) begin
                            r_state <= S_RUN;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rom_init      = r_rom_init;
    assign bus.rom_init_addr = r_rom_addr;
    assign bus.rom_init_data = r_rom_data;
    assign bus.cpu_reset     = r_cpu_reset;
    assign bus.cpu_ce        = r_cpu_ce;
    assign bus.int_n         = r_int_n;
    assign bus.rom_valid     = r_rom_valid;
    assign bus.busy          = r_busy;
`ifdef UCOM43_ROM_SUM_EN
    assign bus.rom_sum       = r_sum;
`endif

endmodule

// File: tb/tb_ucom43_sys_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ucom43_sys_ctrl
//   Directed testbench for ucom43_sys_ctrl. Inputs change on the falling
//   clock edge; outputs are sampled on the falling edge after each rising
//   edge. 'm' counts falling edges relative to the edge at which a download
//   closes, so cycle expectations can be written as simple formulas.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ucom43_sys_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   m;
    int   n_init;
    int   n_bad;
    bit   g_corrupt;

    ucom43_sys_ctrl_if bus();

`ifdef UCOM43_ROM_SUM_EN
    ucom43_sys_ctrl #(
        .ROM_SIZE (2048),
        .CE_DIV   (4),
        .RST_HOLD (16),
        .INT_PULSE(8),
        .EXP_SUM  (16'hFC00)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );
`else
    ucom43_sys_ctrl #(
        .ROM_SIZE (2048),
        .CE_DIV   (4),
        .RST_HOLD (16),
        .INT_PULSE(8)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_data(input logic [15:0] a);
        logic [7:0] d;
        d = a[7:0];
        if (g_corrupt && (a == 16'd0)) d = d + 8'd1;
        return d;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (m=%0d): got %0h expected %0h", tag, m, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        m++;
    endtask

    // ROM-init monitor: writes arrive in address order 0,1,2,... in every load.
    always @(negedge clk) begin
        if (bus.rom_init === 1'b1) begin
            if ((bus.rom_init_addr !== n_init[11:0]) ||
                (bus.rom_init_data !== exp_data(16'(n_init))))
                n_bad++;
            n_init++;
        end
    end

    // Writes bytes 0..n-1; optionally drops dl_active together with the last
    // write, optionally adds out-of-range writes. Returns with m=0 at the
    // falling edge right after the edge that closes the load.
    task automatic download(input int unsigned n, input bit fall_with_last, input bit extra);
        n_init = 0;
        n_bad  = 0;
        bus.dl_active = 1'b1;
        step();
        for (int unsigned i = 0; i < n; i++) begin
            bus.dl_wr   = 1'b1;
            bus.dl_addr = 16'(i);
            bus.dl_data = exp_data(16'(i));
            if (fall_with_last && (i == n - 1)) bus.dl_active = 1'b0;
            step();
        end
        if (extra) begin
            bus.dl_addr = 16'h0800; bus.dl_data = 8'hAA; step();
            bus.dl_addr = 16'h0900; bus.dl_data = 8'h55; step();
        end
        bus.dl_wr = 1'b0;
        if (!fall_with_last) begin
            bus.dl_active = 1'b0;
            step();
        end
        m = 0;
    endtask

    initial begin
        int viol;
        n_chk = 0; n_err = 0; m = 0; n_init = 0; n_bad = 0; g_corrupt = 1'b0;
        rst = 1'b1;
        bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.pause = 1'b0; bus.int_btn = 1'b0;
        step(); step();

        check_eq("rst_rom_init",  32'(bus.rom_init),      32'd0);
        check_eq("rst_rom_addr",  32'(bus.rom_init_addr), 32'd0);
        check_eq("rst_rom_data",  32'(bus.rom_init_data), 32'd0);
        check_eq("rst_cpu_reset", 32'(bus.cpu_reset),     32'd1);
        check_eq("rst_cpu_ce",    32'(bus.cpu_ce),        32'd0);
        check_eq("rst_int_n",     32'(bus.int_n),         32'd1);
        check_eq("rst_rom_valid", 32'(bus.rom_valid),     32'd0);
        check_eq("rst_busy",      32'(bus.busy),          32'd1);
        rst = 1'b0;

        // Power-up with no download: stays in reset, no cpu_ce.
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.cpu_ce !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.busy !== 1'b1) viol++;
        end
        check_eq("idle_violations", 32'(viol), 32'd0);

        // Full image; last byte written in the cycle dl_active falls.
        download(2048, 1'b1, 1'b0);
        check_eq("load1_rom_valid", 32'(bus.rom_valid), 32'd1);
        check_eq("load1_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        for (int i = 1; i <= 28; i++) begin
            step();
            check_eq("hold_cpu_reset", 32'(bus.cpu_reset), 32'((m < 16) ? 1 : 0));
            check_eq("hold_busy",      32'(bus.busy),      32'((m < 16) ? 1 : 0));
            check_eq("run_cpu_ce",     32'(bus.cpu_ce),    32'((m >= 20 && ((m - 20) % 4) == 0) ? 1 : 0));
        end
        check_eq("load1_init_count", 32'(n_init), 32'd2048);
        check_eq("load1_init_bad",   32'(n_bad),  32'd0);
        check_eq("run_rom_valid",    32'(bus.rom_valid), 32'd1);

        // Interrupt: press at m=28 for 3 clks, re-press at m=40 (ignored).
        bus.int_btn = 1'b1;
        for (int i = 29; i <= 64; i++) begin
            step();
            check_eq("int_n",     32'(bus.int_n),  32'((m >= 31 && m <= 60) ? 0 : 1));
            check_eq("int_cpu_ce", 32'(bus.cpu_ce), 32'(((m % 4) == 0) ? 1 : 0));
            if (m == 31 || m == 43) bus.int_btn = 1'b0;
            if (m == 40) bus.int_btn = 1'b1;
        end

        // Press at m=64, pause 50 clks after the third tick.
        bus.int_btn = 1'b1;
        for (int i = 65; i <= 150; i++) begin
            step();
            check_eq("pause_int_n", 32'(bus.int_n), 32'((m >= 67 && m <= 147) ? 0 : 1));
            check_eq("pause_cpu_ce", 32'(bus.cpu_ce),
                     32'(((m <= 76 && (m % 4) == 0) || (m >= 131 && ((m - 131) % 4) == 0)) ? 1 : 0));
            if (m == 100) begin
                check_eq("paused_busy",      32'(bus.busy),      32'd0);
                check_eq("paused_cpu_reset", 32'(bus.cpu_reset), 32'd0);
            end
            if (m == 67)  bus.int_btn = 1'b0;
            if (m == 77)  bus.pause   = 1'b1;
            if (m == 127) bus.pause   = 1'b0;
        end

        // dl_active rises in RUN during an interrupt pulse.
        bus.int_btn = 1'b1;
        for (int i = 151; i <= 156; i++) begin
            step();
            if (m == 153) bus.int_btn = 1'b0;
            if (m == 155) begin
                check_eq("pre_dl_int_n",     32'(bus.int_n),     32'd0);
                check_eq("pre_dl_rom_valid", 32'(bus.rom_valid), 32'd1);
                bus.dl_active = 1'b1;
            end
        end
        check_eq("dl_run_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check_eq("dl_run_int_n",     32'(bus.int_n),     32'd1);
        check_eq("dl_run_rom_valid", 32'(bus.rom_valid), 32'd0);
        check_eq("dl_run_busy",      32'(bus.busy),      32'd1);
        check_eq("dl_run_cpu_ce",    32'(bus.cpu_ce),    32'd0);

        // Short image (2047 bytes) plus writes to 0x0800 and 0x0900.
        download(2047, 1'b0, 1'b1);
        check_eq("short_rom_valid", 32'(bus.rom_valid), 32'd0);
        check_eq("short_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check_eq("short_busy",      32'(bus.busy),      32'd1);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.cpu_ce !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.rom_init !== 1'b0) viol++;
        end
        check_eq("short_idle_violations", 32'(viol), 32'd0);
        check_eq("short_init_count",      32'(n_init), 32'd2047);
        check_eq("short_init_bad",        32'(n_bad),  32'd0);

`ifdef UCOM43_ROM_SUM_EN
        // Full byte count but one byte off: sum 0xFC01 != EXP_SUM.
        g_corrupt = 1'b1;
        download(2048, 1'b1, 1'b0);
        check_eq("sum_value",     32'(bus.rom_sum),   32'h0000FC01);
        check_eq("sum_rom_valid", 32'(bus.rom_valid), 32'd0);
        step(); step();
        check_eq("sum_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check_eq("sum_busy",      32'(bus.busy),      32'd1);
        check_eq("sum_init_count", 32'(n_init), 32'd2048);
        check_eq("sum_init_bad",   32'(n_bad),  32'd0);
        g_corrupt = 1'b0;
`endif

        // Reset asserted while a ROM write is being presented.
        bus.dl_active = 1'b1;
        step();
        bus.dl_wr = 1'b1; bus.dl_addr = 16'h0005; bus.dl_data = 8'h05;
        step();
        check_eq("midload_rom_init", 32'(bus.rom_init),      32'd1);
        check_eq("midload_rom_addr", 32'(bus.rom_init_addr), 32'h005);
        rst = 1'b1;
        #1;
        check_eq("midrst_rom_init",  32'(bus.rom_init),      32'd0);
        check_eq("midrst_rom_addr",  32'(bus.rom_init_addr), 32'd0);
        check_eq("midrst_rom_data",  32'(bus.rom_init_data), 32'd0);
        check_eq("midrst_rom_valid", 32'(bus.rom_valid),     32'd0);
        check_eq("midrst_cpu_reset", 32'(bus.cpu_reset),     32'd1);
        bus.dl_wr = 1'b0; bus.dl_active = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
